// File: rtl/mem_map_pkg.sv
// Memory map shared by memory_system, the control unit and the testbench.
// Holds the default region boundaries, the region-select encoding, the default
// program ROM image and the address-to-region decode helper.
package mem_map_pkg;

    localparam logic [7:0] RAM_BASE_DEF = 8'h80;
    localparam logic [7:0] OUT_BASE_DEF = 8'hE0;
    localparam logic [7:0] IN_BASE_DEF  = 8'hF0;
    localparam int         N_PORTS_DEF  = 16;

    // Default 128-byte program image, byte k at bits [8k+7:8k].
    localparam logic [1023:0] ROM_IMAGE_DEF = {1008'h0, 8'hAA, 8'h86};

    typedef enum logic [1:0] {
        REG_ROM = 2'd0,
        REG_RAM = 2'd1,
        REG_OUT = 2'd2,
        REG_IN  = 2'd3
    } region_e;

    // Every 8-bit address falls into exactly one region; the bases are ascending.
    function automatic region_e decode_region(
        input logic [7:0] addr,
        input logic [7:0] ram_base,
        input logic [7:0] out_base,
        input logic [7:0] in_base
    );
        region_e r;
        if (addr < ram_base) begin
            r = REG_ROM;
        end else if (addr < out_base) begin
            r = REG_RAM;
        end else if (addr < in_base) begin
            r = REG_OUT;
        end else begin
            r = REG_IN;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_96x8.sv
// Data RAM, 96 x 8, synchronous read-before-write.
// A read and a write to the same word on one edge return the old contents.
// The array itself is never cleared; a write presented while reset is held is dropped.
// Ports: clk, rst_n (async active-low, clears only the read register),
//        addr[6:0] word address, we write enable, wdata[7:0], rdata[7:0] registered.
module ram_96x8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] addr,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    localparam logic [6:0] DEPTH = 7'd96;

    logic [7:0] mem_r [96];
    logic [7:0] rdata_r;
    logic       in_range_s;

    assign in_range_s = (addr < DEPTH);

    // Read old word, then optionally overwrite it; reset branch leaves the array alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 8'h00;
        end else begin
            if (in_range_s) begin
                rdata_r <= mem_r[addr];
                if (we) begin
                    mem_r[addr] <= wdata;
                end
            end else begin
                rdata_r <= 8'h00;
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/rom_128x8.sv
// Program ROM, 128 x 8, synchronous read.
// Contents come from the ROM_IMAGE parameter (byte k at [8k+7:8k]), so the image
// is fixed at elaboration and never changes at run time.
// Ports: clk, rst_n (async active-low, clears only the read register),
//        addr[6:0] read address, rdata[7:0] registered read data.
module rom_128x8 #(
    parameter logic [1023:0] ROM_IMAGE = mem_map_pkg::ROM_IMAGE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] addr,
    output logic [7:0] rdata
);

    logic [7:0] rdata_r;

    // Registered ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 8'h00;
        end else begin
            rdata_r <= ROM_IMAGE[{addr, 3'b000} +: 8];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/memory_system.sv
// Responder side of the CPU memory bus.
// Decodes the 8-bit address into program ROM, data RAM, output ports and input
// ports. Reads have one cycle of latency; writes land on the rising edge.
// Ports:
//   Clk, Reset       clock, asynchronous active-low reset
//   address[7:0]     byte address from the MAR
//   to_memory[7:0]   write data
//   write            write strobe, sampled on rising Clk
//   from_memory[7:0] read data, one cycle after the address
//   port_in          N_PORTS input bytes, asynchronous, double-synchronised
//   port_out         N_PORTS output bytes, registered, readable back
module memory_system
    import mem_map_pkg::*;
#(
    parameter logic [1023:0] ROM_IMAGE = ROM_IMAGE_DEF,
    parameter logic [7:0]    RAM_BASE  = RAM_BASE_DEF,
    parameter logic [7:0]    OUT_BASE  = OUT_BASE_DEF,
    parameter logic [7:0]    IN_BASE   = IN_BASE_DEF,
    parameter int            N_PORTS   = N_PORTS_DEF
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [7:0]             address,
    input  logic [7:0]             to_memory,
    input  logic                   write,
    output logic [7:0]             from_memory,
    input  logic [8*N_PORTS-1:0]   port_in,
    output logic [8*N_PORTS-1:0]   port_out
);

    localparam int PW = $clog2(N_PORTS);

    region_e            region_s;
    region_e            region_r;
    logic [7:0]         ram_off_s;
    logic [7:0]         out_off_s;
    logic [7:0]         in_off_s;
    logic [PW-1:0]      out_idx_s;
    logic [PW-1:0]      in_idx_s;
    logic               ram_we_s;
    logic               out_we_s;
    logic [7:0]         rom_data_s;
    logic [7:0]         ram_data_s;
    logic [7:0]         port_rd_r;
    logic [7:0]         from_memory_s;
    logic [8*N_PORTS-1:0] sync1_r;
    logic [8*N_PORTS-1:0] sync2_r;
    logic [8*N_PORTS-1:0] out_r;
    logic               unused_s;

    assign region_s  = decode_region(address, RAM_BASE, OUT_BASE, IN_BASE);
    assign ram_off_s = address - RAM_BASE;
    assign out_off_s = address - OUT_BASE;
    assign in_off_s  = address - IN_BASE;
    assign out_idx_s = out_off_s[PW-1:0];
    assign in_idx_s  = in_off_s[PW-1:0];
    // Upper offset bits are zero whenever their region is selected.
    assign unused_s  = ^{ram_off_s[7], out_off_s[7:PW], in_off_s[7:PW]};

    // An X strobe compares false and therefore never writes.
    assign ram_we_s = (write == 1'b1) && (region_s == REG_RAM);
    assign out_we_s = (write == 1'b1) && (region_s == REG_OUT);

    rom_128x8 #(
        .ROM_IMAGE (ROM_IMAGE)
    ) u_rom (
        .clk   (Clk),
        .rst_n (Reset),
        .addr  (address[6:0]),
        .rdata (rom_data_s)
    );

    ram_96x8 u_ram (
        .clk   (Clk),
        .rst_n (Reset),
        .addr  (ram_off_s[6:0]),
        .we    (ram_we_s),
        .wdata (to_memory),
        .rdata (ram_data_s)
    );

    // Input synchroniser, output port registers, and the registered port read path.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_r   <= {(8*N_PORTS){1'b0}};
            sync2_r   <= {(8*N_PORTS){1'b0}};
            out_r     <= {(8*N_PORTS){1'b0}};
            region_r  <= REG_ROM;
            port_rd_r <= 8'h00;
        end else begin
            sync1_r  <= port_in;
            sync2_r  <= sync1_r;
            region_r <= region_s;
            // Readback uses the pre-edge register value, giving read-before-write.
            case (region_s)
                REG_OUT: port_rd_r <= out_r[{out_idx_s, 3'b000} +: 8];
                REG_IN:  port_rd_r <= sync2_r[{in_idx_s, 3'b000} +: 8];
                default: port_rd_r <= 8'h00;
            endcase
            if (out_we_s) begin
                out_r[{out_idx_s, 3'b000} +: 8] <= to_memory;
            end else begin
                out_r <= out_r;
            end
        end
    end

    // Select among the already-registered read sources using the registered region.
    always_comb begin
        from_memory_s = 8'h00;
        case (region_r)
            REG_ROM: from_memory_s = rom_data_s;
            REG_RAM: from_memory_s = ram_data_s;
            REG_OUT: from_memory_s = port_rd_r;
            REG_IN:  from_memory_s = port_rd_r;
            default: from_memory_s = 8'h00;
        endcase
    end

    assign from_memory = from_memory_s;
    assign port_out    = out_r;

endmodule

// File: tb/tb_memory_system.sv
// Directed testbench for memory_system: hand-computed expected values for ROM
// reads, RAM read-before-write, output port write/readback, input port latency
// and asynchronous reset behaviour.
module tb_memory_system;

    logic         Clk;
    logic         Reset;
    logic [7:0]   address;
    logic [7:0]   to_memory;
    logic         write;
    logic [7:0]   from_memory;
    logic [127:0] port_in;
    logic [127:0] port_out;

    int checks_cnt;
    int errors_cnt;

    memory_system dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .address     (address),
        .to_memory   (to_memory),
        .write       (write),
        .from_memory (from_memory),
        .port_in     (port_in),
        .port_out    (port_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
        checks_cnt = checks_cnt + 1;
        if (actual !== expected) begin
            errors_cnt = errors_cnt + 1;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        address   = a;
        to_memory = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        Reset      = 1'b0;
        address    = 8'h00;
        to_memory  = 8'h00;
        write      = 1'b0;
        port_in    = 128'h0;

        tick();
        tick();
        check_val("rst_from_memory", {120'h0, from_memory}, 128'h0);
        check_val("rst_port_out", port_out, 128'h0);
        Reset = 1'b1;

        // ROM reads, one cycle of latency.
        address = 8'h00;
        tick();
        check_val("rom_00", {120'h0, from_memory}, 128'h86);
        address = 8'h01;
        #1;
        check_val("rom_01_latency", {120'h0, from_memory}, 128'h86);
        tick();
        check_val("rom_01", {120'h0, from_memory}, 128'hAA);

        // RAM write then read back.
        do_write(8'h80, 8'h5A);
        tick();
        check_val("ram_80", {120'h0, from_memory}, 128'h5A);

        // Writes into ROM range are ignored.
        do_write(8'h01, 8'h55);
        tick();
        check_val("rom_write_ignored", {120'h0, from_memory}, 128'hAA);

        // Output port 3 write and readback.
        do_write(8'hE3, 8'hC3);
        check_val("port_out_e3", port_out, 128'h0000_0000_0000_0000_0000_0000_C300_0000);
        tick();
        check_val("readback_e3", {120'h0, from_memory}, 128'hC3);

        // Input port 0 latency: change just after edge 0, visible after edge 3.
        address = 8'hF0;
        tick();
        port_in[7:0] = 8'h3C;
        tick();
        check_val("in_f0_edge1", {120'h0, from_memory}, 128'h0);
        tick();
        check_val("in_f0_edge2", {120'h0, from_memory}, 128'h0);
        tick();
        check_val("in_f0_edge3", {120'h0, from_memory}, 128'h3C);

        // Input port 5 with a different value.
        port_in[47:40] = 8'hD7;
        address = 8'hF5;
        tick();
        tick();
        tick();
        check_val("in_f5", {120'h0, from_memory}, 128'hD7);

        // Read-before-write on the same RAM word.
        do_write(8'h81, 8'h11);
        do_write(8'h81, 8'h22);
        check_val("rbw_old", {120'h0, from_memory}, 128'h11);
        tick();
        check_val("rbw_new", {120'h0, from_memory}, 128'h22);

        // Write held high across a changing address.
        address   = 8'h82;
        to_memory = 8'hA1;
        write     = 1'b1;
        tick();
        address   = 8'h83;
        to_memory = 8'hB2;
        tick();
        write     = 1'b0;
        address   = 8'h82;
        tick();
        check_val("burst_82", {120'h0, from_memory}, 128'hA1);
        address = 8'h83;
        tick();
        check_val("burst_83", {120'h0, from_memory}, 128'hB2);

        // Reset mid-cycle clears ports and read data but not RAM.
        do_write(8'hE0, 8'hFF);
        do_write(8'h90, 8'h77);
        tick();
        check_val("ram_90_pre", {120'h0, from_memory}, 128'h77);
        check_val("port_out_pre", port_out,
                  128'h0000_0000_0000_0000_0000_0000_C300_00FF);
        #2;
        Reset = 1'b0;
        #1;
        check_val("rst_mid_port_out", port_out, 128'h0);
        check_val("rst_mid_from_memory", {120'h0, from_memory}, 128'h0);
        // A write while reset is held is lost.
        address   = 8'h90;
        to_memory = 8'h99;
        write     = 1'b1;
        tick();
        write = 1'b0;
        Reset = 1'b1;
        tick();
        check_val("ram_90_post", {120'h0, from_memory}, 128'h77);
        address = 8'hE0;
        tick();
        check_val("readback_e0_post", {120'h0, from_memory}, 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
